// File: rtl/rate_pkg.sv
// Shared constants and state encoding for the windowed rate accumulator.
// Samples and results are unsigned Q9.4.
package rate_pkg;

    localparam int M         = 13;
    localparam int FRAC_BITS = 4;
    localparam int LOG2_WIN  = 4;
    localparam int ACC_W     = M + LOG2_WIN;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rate_lane_acc.sv
// One accumulation lane: running sum of samples plus the truncated
// window mean of (sum + current sample).
module rate_lane_acc #(
    parameter int M        = 13,
    parameter int LOG2_WIN = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         add,
    input  logic [M-1:0] smp,
    output logic [M-1:0] mean
);

    localparam int AW = M + LOG2_WIN;

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;

    assign sum  = acc + {{LOG2_WIN{1'b0}}, smp};
    assign mean = sum[AW-1:LOG2_WIN];

    // Clear wins over add so the closing sample starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/rate_window_acc.sv
// Windowed mean of E/I rate samples with valid/ready on both sides.
// Optional macro RE_FLOOR_EN forces a zero rE mean up to one LSB.
module rate_window_acc #(
    parameter int M        = 13,
    parameter int LOG2_WIN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M-1:0]        e_smp,
    input  logic [M-1:0]        i_smp,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [M-1:0]        rE,
    output logic [M-1:0]        rI,
    output logic [LOG2_WIN-1:0] win_cnt
);

    import rate_pkg::*;

    state_t       state;
    logic         accept;
    logic         last;
    logic         lane_clr;
    logic         lane_add;
    logic [M-1:0] mean_e;
    logic [M-1:0] mean_i;
    logic [M-1:0] re_next;

    assign accept = in_valid && in_ready;
    assign last   = &win_cnt;

    // Lane controls: flush or closing sample clears, other accepts add.
    always_comb begin
        lane_clr = 1'b0;
        lane_add = 1'b0;
        if (state == ACC) begin
            lane_clr = flush || (accept && last);
            lane_add = accept && !flush && !last;
        end
    end

    // Optional divisor floor so the divider never sees rE = 0.
    always_comb begin
        re_next = mean_e;
`ifdef RE_FLOOR_EN
        if (mean_e == '0) begin
            re_next = {{(M-1){1'b0}}, 1'b1};
        end
`else
        re_next = mean_e;
`endif
    end

    rate_lane_acc #(
        .M        (M),
        .LOG2_WIN (LOG2_WIN)
    ) u_lane_e (
        .clk  (clk),
        .rst  (rst),
        .clr  (lane_clr),
        .add  (lane_add),
        .smp  (e_smp),
        .mean (mean_e)
    );

    rate_lane_acc #(
        .M        (M),
        .LOG2_WIN (LOG2_WIN)
    ) u_lane_i (
        .clk  (clk),
        .rst  (rst),
        .clr  (lane_clr),
        .add  (lane_add),
        .smp  (i_smp),
        .mean (mean_i)
    );

    // Window FSM with registered handshake outputs and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            win_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rE        <= '0;
            rI        <= '0;
        end else begin
            unique case (state)
                ACC: begin
                    if (flush) begin
                        win_cnt <= '0;
                    end else if (accept) begin
                        win_cnt <= win_cnt + 1'b1;
                        if (last) begin
                            rE        <= re_next;
                            rI        <= mean_i;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rate_window_acc.sv
// Directed bench for rate_window_acc: window means, backpressure,
// truncation, flush, max values and reset during HOLD.
module tb_rate_window_acc;

    localparam int M  = 13;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [M-1:0]  e_smp;
    logic [M-1:0]  i_smp;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  rE;
    logic [M-1:0]  rI;
    logic [LW-1:0] win_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rate_window_acc #(
        .M        (M),
        .LOG2_WIN (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .e_smp     (e_smp),
        .i_smp     (i_smp),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rE        (rE),
        .rI        (rI),
        .win_cnt   (win_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [M-1:0] e, input logic [M-1:0] i,
                        input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            e_smp    = e;
            i_smp    = i;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [M-1:0] exp_floor;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        e_smp     = '0;
        i_smp     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rE", 32'(rE), 32'h0);
        chk("rst_rI", 32'(rI), 32'h0);
        chk("rst_win_cnt", 32'(win_cnt), 32'd0);

        // Constant window
        feed(13'h100, 13'h080, 15);
        chk("const_cnt15", 32'(win_cnt), 32'd15);
        chk("const_ov_early", 32'(out_valid), 32'd0);
        feed(13'h100, 13'h080, 1);
        chk("const_ov", 32'(out_valid), 32'd1);
        chk("const_rE", 32'(rE), 32'h100);
        chk("const_rI", 32'(rI), 32'h080);
        chk("const_cnt0", 32'(win_cnt), 32'd0);

        // Backpressure with upstream still offering samples
        in_valid = 1'b1;
        e_smp    = 13'h1234;
        i_smp    = 13'h0777;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_rE", 32'(rE), 32'h100);
            chk("bp_rI", 32'(rI), 32'h080);
        end
        chk("bp_cnt", 32'(win_cnt), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_rE_kept", 32'(rE), 32'h100);
        chk("hs_cnt", 32'(win_cnt), 32'd0);
        tick();
        chk("resume_cnt", 32'(win_cnt), 32'd1);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1_cnt", 32'(win_cnt), 32'd0);

        // Ramp: e = k*0x10, i = k, k = 0..15
        for (int k = 0; k < 16; k++) begin
            feed(13'(k * 16), 13'(k), 1);
        end
        chk("ramp_rE", 32'(rE), 32'h078);
        chk("ramp_rI", 32'(rI), 32'h007);
        release_out();

        // Truncation
        feed(13'h001, 13'h0F0, 15);
        feed(13'h000, 13'h0F0, 1);
`ifdef RE_FLOOR_EN
        exp_floor = 13'h001;
`else
        exp_floor = 13'h000;
`endif
        chk("trunc_rE", 32'(rE), 32'(exp_floor));
        chk("trunc_rI", 32'(rI), 32'h0F0);
        release_out();

        // Flush mid-window, sample in same cycle discarded
        feed(13'h1FFF, 13'h1FFF, 7);
        chk("flush_cnt7", 32'(win_cnt), 32'd7);
        flush = 1'b1;
        feed(13'h1FFF, 13'h1FFF, 1);
        flush = 1'b0;
        chk("flush_cnt0", 32'(win_cnt), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        feed(13'h010, 13'h010, 16);
        chk("flush_rE", 32'(rE), 32'h010);
        chk("flush_rI", 32'(rI), 32'h010);

        // Flush in HOLD is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hflush_ov", 32'(out_valid), 32'd1);
        chk("hflush_rE", 32'(rE), 32'h010);
        release_out();

        // Max values
        feed(13'h1FFF, 13'h1FFF, 16);
        chk("max_ov", 32'(out_valid), 32'd1);
        chk("max_rE", 32'(rE), 32'h1FFF);
        chk("max_rI", 32'(rI), 32'h1FFF);

        // Reset while holding a result
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("hrst_ov", 32'(out_valid), 32'd0);
        chk("hrst_rE", 32'(rE), 32'h0);
        chk("hrst_rI", 32'(rI), 32'h0);
        chk("hrst_cnt", 32'(win_cnt), 32'd0);
        chk("hrst_in_ready", 32'(in_ready), 32'd1);

        // Accumulators really cleared by reset
        feed(13'h020, 13'h040, 16);
        chk("post_rE", 32'(rE), 32'h020);
        chk("post_rI", 32'(rI), 32'h040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
